// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic CORE = 1'b0;
  localparam logic DBG  = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter connects through the slave modport; requesters/memory model use master.
interface dmem_arb_if #(
  parameter int WIDTH = 32
) ();

  logic             core_req;
  logic             core_we;
  logic [WIDTH-1:0] core_addr;
  logic [WIDTH-1:0] core_wdata;
  logic             core_gnt;

  logic             dbg_req;
  logic             dbg_we;
  logic [WIDTH-1:0] dbg_addr;
  logic [WIDTH-1:0] dbg_wdata;
  logic             dbg_gnt;

  logic [1:0]       rvalid;
  logic [WIDTH-1:0] rdata;

  logic             read_en;
  logic             write_en;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] mem_data;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_data,
    output core_gnt, dbg_gnt, rvalid, rdata,
    output read_en, write_en, addr, write_data
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_data,
    input  core_gnt, dbg_gnt, rvalid, rdata,
    input  read_en, write_en, addr, write_data
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Two-way winner picker: round-robin on the last grant, or fixed debug priority
// when DMEM_ARB_DBG_PRIO_EN is defined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

`ifdef DMEM_ARB_DBG_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = CORE;
    if (req[DBG]) win = DBG;
  end
`else
  always_comb begin
    win = CORE;
    if (req[CORE] && req[DBG]) win = ~last;
    else if (req[DBG])         win = DBG;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and debug load/store requests onto one data memory port.
// Optional build macro: DMEM_ARB_DBG_PRIO_EN (debug wins contested cycles).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  dmem_arb_if.slave  bus
);

  state_t           state_q, state_d;
  logic             win_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             last_q;

  logic [1:0]       req_vec;
  logic             pick_win;

  logic             core_gnt_c, dbg_gnt_c;
  logic [1:0]       rvalid_c;
  logic [WIDTH-1:0] rdata_c;
  logic             read_en_c, write_en_c;
  logic [WIDTH-1:0] addr_c, write_data_c;

  assign req_vec = {bus.dbg_req, bus.core_req};

  dmem_arb_pick u_pick (
    .req  (req_vec),
    .last (last_q),
    .win  (pick_win)
  );

  // last_q resets to DBG so the core wins the first contested cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= DBG;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req_vec) begin
        win_q   <= pick_win;
        we_q    <= (pick_win == DBG) ? bus.dbg_we    : bus.core_we;
        addr_q  <= (pick_win == DBG) ? bus.dbg_addr  : bus.core_addr;
        wdata_q <= (pick_win == DBG) ? bus.dbg_wdata : bus.core_wdata;
      end
      if (state_q == ACCESS) last_q <= win_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    core_gnt_c   = 1'b0;
    dbg_gnt_c    = 1'b0;
    rvalid_c     = 2'b00;
    rdata_c      = '0;
    read_en_c    = 1'b0;
    write_en_c   = 1'b0;
    addr_c       = '0;
    write_data_c = '0;
    case (state_q)
      IDLE: begin
        if (|req_vec) state_d = ACCESS;
      end
      ACCESS: begin
        core_gnt_c   = (win_q == CORE);
        dbg_gnt_c    = (win_q == DBG);
        read_en_c    = ~we_q;
        write_en_c   = we_q;
        addr_c       = addr_q;
        write_data_c = wdata_q;
        state_d      = we_q ? IDLE : RESP;
      end
      RESP: begin
        rvalid_c = (win_q == DBG) ? 2'b10 : 2'b01;
        rdata_c  = bus.mem_data;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.core_gnt   = core_gnt_c;
  assign bus.dbg_gnt    = dbg_gnt_c;
  assign bus.rvalid     = rvalid_c;
  assign bus.rdata      = rdata_c;
  assign bus.read_en    = read_en_c;
  assign bus.write_en   = write_en_c;
  assign bus.addr       = addr_c;
  assign bus.write_data = write_data_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level schedule model.
module tb_dmem_arbiter;

  localparam int W  = 32;
  localparam int NC = 400;
`ifdef DMEM_ARB_DBG_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arb_if #(.WIDTH(W)) bus ();

  dmem_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic         who;
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] mem;
    logic [1:0]   exp_gnt;
    logic         exp_rd;
    logic         exp_wr;
    logic [1:0]   exp_rv;
    logic [W-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0]   gnt;
    logic         rd;
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [1:0]   rv;
    logic         live;
  } exp_t;

  vec_t vt[4];
  exp_t ex[NC+4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;
  endtask

  task automatic set_req(input logic who, input logic we, input logic [W-1:0] a,
                         input logic [W-1:0] d);
    if (who) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    end else begin
      bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b01, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h55AA55AA, 2'b10, 1'b0, 1'b1, 2'b00, 32'h0};
    vt[2] = '{1'b0, 1'b1, 32'h44, 32'hA5A5F00F, 32'h11112222, 2'b01, 1'b0, 1'b1, 2'b00, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0BADF00D, 2'b10, 1'b1, 1'b0, 2'b10, 32'h0BADF00D};

    // reset with both requests up: nothing may leave the arbiter
    clear_reqs();
    bus.mem_data = 32'hFFFF0000;
    set_req(1'b0, 1'b0, 32'h8, 32'h1);
    set_req(1'b1, 1'b1, 32'hC, 32'h2);
    rst = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_gnt",   {bus.dbg_gnt, bus.core_gnt}, 2'b00);
    chk("rst_rv",    bus.rvalid, 2'b00);
    chk("rst_strb",  {bus.read_en, bus.write_en}, 2'b00);
    chk("rst_addr",  bus.addr, 32'h0);
    chk("rst_wdata", bus.write_data, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    next_cycle();
    clear_reqs();
    rst = 1'b1;
    next_cycle();

    // single-transaction vector table
    for (int i = 0; i < 4; i++) begin
      set_req(vt[i].who, vt[i].we, vt[i].a, vt[i].d);
      bus.mem_data = vt[i].mem;
      @(negedge clk);
      chk($sformatf("v%0d_idle_gnt", i), {bus.dbg_gnt, bus.core_gnt}, 2'b00);
      next_cycle();
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i),   {bus.dbg_gnt, bus.core_gnt}, vt[i].exp_gnt);
      chk($sformatf("v%0d_rd", i),    bus.read_en, vt[i].exp_rd);
      chk($sformatf("v%0d_wr", i),    bus.write_en, vt[i].exp_wr);
      chk($sformatf("v%0d_addr", i),  bus.addr, vt[i].a);
      chk($sformatf("v%0d_wdata", i), bus.write_data, vt[i].we ? vt[i].d : 32'h0);
      chk($sformatf("v%0d_rv_early", i), bus.rvalid, 2'b00);
      next_cycle();
      clear_reqs();
      @(negedge clk);
      chk($sformatf("v%0d_rv", i),    bus.rvalid, vt[i].exp_rv);
      chk($sformatf("v%0d_rdata", i), bus.rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_gnt2", i),  {bus.dbg_gnt, bus.core_gnt}, 2'b00);
      next_cycle();
    end

    // address change while the access is in flight
    bus.mem_data = 32'h13579BDF;
    set_req(1'b0, 1'b0, 32'h10, 32'h0);
    next_cycle();
    bus.core_addr = 32'h30;
    @(negedge clk);
    chk("hold_addr", bus.addr, 32'h10);
    chk("hold_rd",   bus.read_en, 1'b1);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    chk("hold_rv",    bus.rvalid, 2'b01);
    chk("hold_rdata", bus.rdata, 32'h13579BDF);
    next_cycle();

    // reset during the response cycle of a core load
    bus.mem_data = 32'hCAFEF00D;
    set_req(1'b0, 1'b0, 32'h40, 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_resp_rv", bus.rvalid, 2'b01);
    next_cycle();
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    chk("abort_rv",   bus.rvalid, 2'b00);
    chk("abort_strb", {bus.read_en, bus.write_en}, 2'b00);
    chk("abort_gnt",  {bus.dbg_gnt, bus.core_gnt}, 2'b00);
    chk("abort_rdata", bus.rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("abort_rv2",  bus.rvalid, 2'b00);
    chk("abort_gnt2", {bus.dbg_gnt, bus.core_gnt}, 2'b00);
    next_cycle();

    // both requesters held high: four grants
    do_reset();
    set_req(1'b0, 1'b1, 32'h100, 32'hC0C0C0C0);
    set_req(1'b1, 1'b1, 32'h200, 32'hDBDBDBDB);
    begin
      int gcount = 0;
      for (int cyc = 0; cyc < 16 && gcount < 4; cyc++) begin
        @(negedge clk);
        if (bus.core_gnt || bus.dbg_gnt) begin
          chk($sformatf("rr_grant%0d", gcount), {bus.dbg_gnt, bus.core_gnt},
              (PRIO || (gcount % 2 == 1)) ? 2'b10 : 2'b01);
          chk($sformatf("rr_addr%0d", gcount), bus.addr,
              (PRIO || (gcount % 2 == 1)) ? 32'h200 : 32'h100);
          gcount++;
        end
        next_cycle();
      end
      chk("rr_count", gcount, 4);
    end
    clear_reqs();
    next_cycle();
    next_cycle();

    // randomized traffic against the schedule model
    do_reset();
    begin
      bit           pend[2];
      bit           pwe[2];
      logic [W-1:0] pa[2];
      logic [W-1:0] pd[2];
      int           drop_at[2];
      int           block_until[2];
      int           free_at;
      int           last_win;
      for (int k = 0; k < NC + 4; k++) ex[k] = '{2'b00, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0};
      for (int r = 0; r < 2; r++) begin
        pend[r] = 1'b0; pwe[r] = 1'b0; pa[r] = '0; pd[r] = '0;
        drop_at[r] = -1; block_until[r] = 0;
      end
      free_at  = 0;
      last_win = 1;
      for (int c = 0; c < NC; c++) begin
        for (int r = 0; r < 2; r++) begin
          if (pend[r] && c == drop_at[r]) begin
            pend[r] = 1'b0;
            block_until[r] = c + 1;
          end
          if (!pend[r] && c >= block_until[r] && $urandom_range(0, 2) == 0) begin
            pend[r] = 1'b1;
            pwe[r]  = $urandom_range(0, 1) == 1;
            pa[r]   = $urandom;
            pd[r]   = $urandom;
          end
        end
        bus.core_req = pend[0]; bus.core_we = pend[0] ? pwe[0] : 1'($urandom_range(0, 1));
        bus.core_addr  = pend[0] ? pa[0] : $urandom;
        bus.core_wdata = pend[0] ? pd[0] : $urandom;
        bus.dbg_req  = pend[1]; bus.dbg_we  = pend[1] ? pwe[1] : 1'($urandom_range(0, 1));
        bus.dbg_addr   = pend[1] ? pa[1] : $urandom;
        bus.dbg_wdata  = pend[1] ? pd[1] : $urandom;
        bus.mem_data   = $urandom;

        if (c >= free_at && (pend[0] || pend[1])) begin
          int w;
          if (pend[0] && pend[1]) w = PRIO ? 1 : 1 - last_win;
          else                    w = pend[1] ? 1 : 0;
          last_win      = w;
          ex[c+1].gnt   = (w == 1) ? 2'b10 : 2'b01;
          ex[c+1].rd    = !pwe[w];
          ex[c+1].wr    = pwe[w];
          ex[c+1].addr  = pa[w];
          ex[c+1].wdata = pd[w];
          if (!pwe[w]) begin
            ex[c+2].rv   = (w == 1) ? 2'b10 : 2'b01;
            ex[c+2].live = 1'b1;
            free_at = c + 3;
          end else begin
            free_at = c + 2;
          end
          drop_at[w] = c + 2;
        end

        @(negedge clk);
        chk($sformatf("rnd%0d_gnt", c),   {bus.dbg_gnt, bus.core_gnt}, ex[c].gnt);
        chk($sformatf("rnd%0d_strb", c),  {bus.read_en, bus.write_en}, {ex[c].rd, ex[c].wr});
        chk($sformatf("rnd%0d_addr", c),  bus.addr, ex[c].addr);
        chk($sformatf("rnd%0d_wdata", c), bus.write_data, ex[c].wdata);
        chk($sformatf("rnd%0d_rv", c),    bus.rvalid, ex[c].rv);
        chk($sformatf("rnd%0d_rdata", c), bus.rdata, ex[c].live ? bus.mem_data : 32'h0);
        next_cycle();
      end
    end
    clear_reqs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving data and address width.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have core_req  input  1  core load/store request; held until core_gnt.
REQ-005 SHALL have core_we  input  1  core request is a store (1) or a load (0).
REQ-006 SHALL have core_addr  input  WIDTH  core byte address.
REQ-007 SHALL have core_wdata  input  WIDTH  core store data.
REQ-008 SHALL have core_gnt  output  1  one-cycle pulse; core request accepted.
REQ-009 SHALL have dbg_req  input  1  debug-port request; held until dbg_gnt.
REQ-010 SHALL have dbg_we  input  1  debug request is a store (1) or a load (0).
REQ-011 SHALL have dbg_addr  input  WIDTH  debug byte address.
REQ-012 SHALL have dbg_wdata  input  WIDTH  debug store data.
REQ-013 SHALL have dbg_gnt  output  1  one-cycle pulse; debug request accepted.
REQ-014 SHALL have rvalid  output  2  load data valid; bit0 core, bit1 debug, one-hot or zero.
REQ-015 SHALL have rdata  output  WIDTH  load data, shared by both requesters.
REQ-016 SHALL have read_en  output  1  data memory read strobe.
REQ-017 SHALL have write_en  output  1  data memory write strobe.
REQ-018 SHALL have addr  output  WIDTH  data memory address.
REQ-019 SHALL have write_data  output  WIDTH  data memory write data.
REQ-020 SHALL have mem_data  input  WIDTH  data memory read data, valid one cycle after read_en.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-022 In IDLE with any req high, SHALL pick a winner, register its we/addr/wdata, and move to ACCESS next cycle; no req: stay IDLE.
REQ-023 In ACCESS, SHALL pulse the winner's gnt, drive addr/write_data from the captured registers, and assert write_en (store) or read_en (load) for exactly that cycle.
REQ-024 From ACCESS, a store SHALL return to IDLE; a load SHALL go to RESP.
REQ-025 In RESP, SHALL drive rdata = mem_data and set the winner's rvalid bit for one cycle, then return to IDLE.
REQ-026 Latency: request seen in IDLE at cycle N -> gnt and strobe at N+1 -> rvalid at N+2 (loads only); store throughput one per 2 cycles, load one per 3.
REQ-027 Arbitration SHALL be round-robin: when both req are high, grant the requester not granted most recently; single request wins regardless of pointer.
REQ-028 Pointer SHALL update only on a grant.
REQ-029 Requests SHALL be sampled only in IDLE; req changes in ACCESS/RESP SHALL NOT alter the in-flight access.
REQ-030 Outside their active cycles, gnt, rvalid, read_en, write_en SHALL be 0; rdata SHALL be 0 when rvalid is 0.
REQ-031 read_en and write_en SHALL never be high together; at most one gnt bit high per cycle.

Reset
REQ-032 When rst is low at a clock edge, SHALL enter IDLE, clear all outputs and captured registers to 0, and set the pointer so core wins the first contested cycle.
REQ-033 Reset during ACCESS or RESP SHALL abort the access with no gnt or rvalid pulse emitted afterward.

Configuration
REQ-034 With DMEM_ARB_DBG_PRIO_EN defined, arbitration SHALL be fixed priority with debug always winning contested cycles; without it, round-robin per REQ-027.

Structure
REQ-035 Package dmem_arb_pkg SHALL hold the FSM state type and the requester index constants (CORE=0, DBG=1).
REQ-036 Winner selection SHALL live in sub-module dmem_arb_pick (2-way round-robin/priority picker).

Verification
REQ-037 Core load addr 0x10, mem_data 0xDEADBEEF -> core_gnt and read_en at N+1, rvalid=01 with rdata 0xDEADBEEF at N+2.
REQ-038 Debug store addr 0x20, data 0x12345678 -> dbg_gnt, write_en, addr 0x20, write_data 0x12345678 at N+1; rvalid stays 00.
REQ-039 Both req held high for 4 grants -> grants alternate core, dbg, core, dbg (with DMEM_ARB_DBG_PRIO_EN: all dbg).
REQ-040 rst low during RESP of a core load -> next cycle IDLE, rvalid 00, all strobes 0.
REQ-041 core_addr changed from 0x10 to 0x30 while in ACCESS -> memory addr stays 0x10.
